// File: rtl/mem_access_unit.sv
// Byte-addressed RV32I load/store front-end for a word-addressed BRAM without byte enables.
// Sub-word stores are done as a read-modify-write of the containing word.
module mem_access_unit #(
    parameter int WORDS      = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  error_o,
    output logic [WORDS-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_rd_no,
    output logic                  mem_wr_no,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_WR     = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [WORDS-1:0]      addr_q, addr_d;
    logic [1:0]            off_q, off_d;
    logic [2:0]            f3_q, f3_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  misaligned, illegal;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] merged;
    logic                  unused_addr;

    assign unused_addr = ^addr_i[31:WORDS+2];

    assign misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                        ((funct3_i == 3'b010) && (addr_i[1:0] != 2'b00));
    assign illegal    = we_i ? !(funct3_i inside {3'b000, 3'b001, 3'b010})
                             :  (funct3_i inside {3'b011, 3'b110, 3'b111});

    assign byte_sel = mem_data_i[{off_q, 3'b000} +: 8];
    assign half_sel = mem_data_i[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b001:  load_ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_ext = mem_data_i;
        endcase
    end

    // Only SB (000) and SH (001) reach the RMW path, so bit 0 picks the lane width.
    always_comb begin
        merged = mem_data_i;
        if (!f3_q[0]) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        off_d      = off_q;
        f3_d       = f3_q;
        wdata_d    = wdata_q;
        mem_data_d = mem_data_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i[WORDS+1:2];
                    off_d   = addr_i[1:0];
                    f3_d    = funct3_i;
                    wdata_d = wdata_i[15:0];
                    if (misaligned || illegal) begin
                        state_d = S_ERR;
                    end else if (!we_i) begin
                        state_d = S_RD;
                    end else if (funct3_i == 3'b010) begin
                        mem_data_d = wdata_i;
                        state_d    = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD: begin
                rdata_d = load_ext;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_WR, S_RMW_WR: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_RMW_RD: begin
                mem_data_d = merged;
                state_d    = S_RMW_WR;
            end
            S_ERR: begin
                done_d  = 1'b1;
                error_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            off_q      <= '0;
            f3_q       <= '0;
            wdata_q    <= '0;
            mem_data_q <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            off_q      <= off_d;
            f3_q       <= f3_d;
            wdata_q    <= wdata_d;
            mem_data_q <= mem_data_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign ready_o    = (state_q == S_IDLE);
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign rdata_o    = rdata_q;
    assign mem_addr_o = addr_q;
    assign mem_data_o = mem_data_q;
    assign mem_rd_no  = !((state_q == S_RD) || (state_q == S_RMW_RD));
    assign mem_wr_no  = !((state_q == S_WR) || (state_q == S_RMW_WR));

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-level reference model predicts each response,
// and a negedge monitor checks strobes, write data, latency and results as done_o appears.
module tb_mem_access_unit;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int unsigned nrd;
        int unsigned nwr;
        int unsigned lat;
        int unsigned done_cyc;
        logic [9:0]  addr;
        logic [31:0] wword;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_i, req_i, we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        ready_o, done_o, error_o;
    logic [31:0] rdata_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_data_o, mem_data_i;
    logic        mem_rd_no, mem_wr_no;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic        init_req;
    logic [31:0] model_rdata;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned rd_cnt, wr_cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit #(.WORDS(10), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .we_i(we_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ready_o(ready_o), .done_o(done_o), .rdata_o(rdata_o), .error_o(error_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_rd_no(mem_rd_no), .mem_wr_no(mem_wr_no), .mem_data_i(mem_data_i)
    );

    // BRAM environment: acts on the negedge inside a strobe cycle.
    always @(negedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
        end else begin
            if (!mem_wr_no) mem[mem_addr_o] <= mem_data_o;
            if (!mem_rd_no) mem_data_i <= mem[mem_addr_o];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte-lane arithmetic on a word array, applied at issue time.
    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        logic [1:0]  off;
        logic [31:0] old, b, h, mask, nw;
        int unsigned sh;
        off     = addr[1:0];
        e.addr  = addr[11:2];
        e.err   = (((f3 == 3'd1) || (f3 == 3'd5)) && addr[0]) || ((f3 == 3'd2) && (off != 2'd0)) ||
                  (we ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7)));
        e.nrd   = 0;
        e.nwr   = 0;
        e.wword = '0;
        old     = ref_mem[e.addr];
        if (!e.err && !we) begin
            e.nrd = 1;
            b = (old >> (8 * off)) & 32'hFF;
            h = (old >> (16 * (off / 2))) & 32'hFFFF;
            case (f3)
                3'd0:    model_rdata = (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
                3'd4:    model_rdata = b;
                3'd1:    model_rdata = (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
                3'd5:    model_rdata = h;
                default: model_rdata = old;
            endcase
        end else if (!e.err) begin
            e.nwr = 1;
            if (f3 == 3'd2) begin
                nw = wd;
            end else begin
                e.nrd = 1;
                sh    = (f3 == 3'd0) ? 8 * off : 16 * (off / 2);
                mask  = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
                nw    = (old & ~mask) | ((wd << sh) & mask);
            end
            ref_mem[e.addr] = nw;
            e.wword = nw;
        end
        e.rdata    = model_rdata;
        e.lat      = (e.nrd == 1 && e.nwr == 1) ? 2 : 1;
        e.done_cyc = 0;
        return e;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 50 && !ready_o; i++) begin
            @(posedge clk); #1;
        end
        if (!ready_o) chk("ready_timeout", {31'b0, ready_o}, 32'd1);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        exp_t e;
        e = model(we, f3, addr, wd);
        wait_ready();
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd;
        @(posedge clk); #1;
        req_i = 1'b0;
        e.done_cyc = cyc + e.lat;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset_i) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (!mem_rd_no) begin
                rd_cnt++;
                if (exp_q.size() != 0) chk("rd_addr", {22'b0, mem_addr_o}, {22'b0, exp_q[0].addr});
            end
            if (!mem_wr_no) begin
                wr_cnt++;
                if (exp_q.size() != 0) begin
                    chk("wr_addr", {22'b0, mem_addr_o}, {22'b0, exp_q[0].addr});
                    chk("wr_data", mem_data_o, exp_q[0].wword);
                end
            end
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", {31'b0, done_o}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("error", {31'b0, error_o}, {31'b0, mon_e.err});
                    chk("rdata", rdata_o, mon_e.rdata);
                    chk("rd_strobes", rd_cnt, mon_e.nrd);
                    chk("wr_strobes", wr_cnt, mon_e.nwr);
                    chk("done_cycle", cyc, mon_e.done_cyc);
                    chk("ready_at_done", {31'b0, ready_o}, 32'd1);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] vf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        exp_t       e;
        int unsigned acc, bad;
        logic        we;
        logic [2:0]  f3;

        reset_i = 1'b1; req_i = 1'b0; we_i = 1'b0; funct3_i = '0; addr_i = '0; wdata_i = '0;
        mem_data_i = '0; model_rdata = '0; rd_cnt = 0; wr_cnt = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        ref_mem[16] = 32'h8899AABB;
        init_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        init_req = 1'b0;
        reset_i  = 1'b0;

        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_error", {31'b0, error_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_mem_addr", {22'b0, mem_addr_o}, 32'd0);
        chk("rst_mem_data", mem_data_o, 32'd0);
        chk("rst_rd_n", {31'b0, mem_rd_no}, 32'd1);
        chk("rst_wr_n", {31'b0, mem_wr_no}, 32'd1);

        issue(1'b0, 3'd0, 32'h41, '0);
        issue(1'b0, 3'd4, 32'h41, '0);
        issue(1'b0, 3'd1, 32'h42, '0);
        issue(1'b0, 3'd5, 32'h42, '0);
        issue(1'b0, 3'd2, 32'h40, '0);
        issue(1'b1, 3'd0, 32'h43, 32'h12345677);
        issue(1'b0, 3'd2, 32'h40, '0);
        issue(1'b1, 3'd2, 32'h40, 32'h8899AABB);
        issue(1'b1, 3'd1, 32'h40, 32'h0000CAFE);
        issue(1'b0, 3'd2, 32'h40, '0);
        issue(1'b1, 3'd2, 32'h7FC, 32'hDEADBEEF);
        issue(1'b0, 3'd2, 32'h800007FC, '0);
        issue(1'b0, 3'd2, 32'h42, '0);
        issue(1'b1, 3'd1, 32'h41, 32'h5555);
        issue(1'b0, 3'd3, 32'h40, '0);
        issue(1'b1, 3'd4, 32'h40, 32'h1);
        drain();

        // Three LW requests with req_i held high, accepted on successive done cycles.
        wait_ready();
        req_i = 1'b1; we_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h40; wdata_i = '0;
        @(posedge clk); #1;
        acc = cyc;
        for (int k = 0; k < 3; k++) begin
            e = model(1'b0, 3'd2, 32'h40, '0);
            e.done_cyc = acc + 1 + 2 * k;
            exp_q.push_back(e);
        end
        repeat (4) @(posedge clk);
        #1;
        req_i = 1'b0;
        drain();

        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 3) != 0) ? vf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            issue(we, f3, ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 127)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();

        // Reset landing on the edge that ends RMW_RD: the write must never happen.
        wait_ready();
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'd0; addr_i = 32'h43; wdata_i = 32'h000000E1;
        @(posedge clk); #1;
        req_i   = 1'b0;
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        model_rdata = '0;
        chk("rstmid_done", {31'b0, done_o}, 32'd0);
        chk("rstmid_rdata", rdata_o, 32'd0);
        chk("rstmid_ready", {31'b0, ready_o}, 32'd1);
        chk("rstmid_wr_n", {31'b0, mem_wr_no}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        issue(1'b0, 3'd2, 32'h40, '0);
        drain();

        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_bad_words", bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
